cordic_rotator: RTL and testbench
=================================

CORDIC_ROTATOR -- requirements
Module: cordic_rotator

Interface
REQ-001 Parameter Q, default 2: integer bits of the signed fixed-point angle and result format.
REQ-002 Parameter F, default 16: fraction bits; word width W = Q+F = 18.
REQ-003 Parameter ITER, default 16: CORDIC iterations per operation, range 1..F.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 angle_in  input  W  signed Q.F radians, from the float-to-fixed converter output.
REQ-008 invalid_in  input  1  converter NaN/Inf flag, sampled with start.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  single-cycle pulse when results are valid.
REQ-011 cos_out  output  W  signed Q.F cosine.
REQ-012 sin_out  output  W  signed Q.F sine.
REQ-013 error  output  1  high when the last operation was rejected.

Function
REQ-014 The FSM SHALL have states IDLE, ITER and DONE.
REQ-015 In IDLE with start=1, the block SHALL capture angle_in and invalid_in and evaluate them.
REQ-016 On capture, invalid_in=1 or |angle_in| > HALF_PI (0x19220) SHALL go directly to DONE, with cos_out=sin_out=0 and error=1.
REQ-017 Otherwise, capture SHALL load x=K_INV (0x09B75), y=0, z=angle_in and an iteration counter i=0, then go to ITER.
REQ-018 Datapath registers SHALL be W+2 bits signed (two guard bits); shifts SHALL be arithmetic.
REQ-019 Each ITER cycle, d=sign(z): x -= d*(y>>>i); y += d*(x>>>i); z -= d*ATAN[i]; i += 1. All right-hand values are pre-update.
REQ-020 After ITER cycles, the FSM SHALL enter DONE and register cos_out=x and sin_out=y, saturated to W bits; error SHALL be 0.
REQ-021 done SHALL be high for exactly the one cycle spent in DONE, and the FSM SHALL then return to IDLE.
REQ-022 Latency: for a valid angle, done SHALL assert ITER+1 cycles after the start-sampling edge; for a rejected angle, after 1 cycle.
REQ-023 start SHALL be ignored while busy=1; no queuing.
REQ-024 cos_out, sin_out and error SHALL hold their values until the next DONE.
REQ-025 Accuracy: results SHALL be within ±4 LSB of the true value for |angle| <= pi/2.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE and clear busy, done, error, cos_out, sin_out, x, y, z and i, including mid-operation.
REQ-027 After release, the first start SHALL be accepted on the first rising edge at which rst_n=1.

Structure
REQ-028 Package cordic_pkg SHALL hold Q, F, W, the state enum, K_INV, HALF_PI, and the ATAN table (round(atan(2^-i)*2^F) for i=0..F-1).
REQ-029 A single combinational sub-module, cordic_iter_step, SHALL implement one micro-rotation (x, y, z, i in; x, y, z out).
REQ-030 The top level SHALL contain only the FSM, counter, registers and saturation.

Verification
REQ-031 angle_in=0x00000, start -> done at +17 cycles; cos_out≈0x10000, sin_out≈0x00000, error=0.
REQ-032 angle_in=0x0860B (pi/6) -> cos_out≈0x0DDB4, sin_out≈0x08000.
REQ-033 angle_in=0x336F0 (-pi/4) -> cos_out≈0x0B505, sin_out≈0x34AFB.
REQ-034 invalid_in=1 or angle_in=0x1A000 -> done at +1 cycle; error=1, outputs 0.
REQ-035 start re-pulsed at cycle 5 of an operation -> ignored; single done at +17 with the first angle's results.
REQ-036 rst_n low at cycle 8 -> busy=0 and outputs 0 immediately; no done; a new start after release completes normally.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC sine/cosine rotator.
// Fixed-point values are signed Q.F radians or unitless magnitudes.
package cordic_pkg;

  localparam int Q  = 2;
  localparam int F  = 16;
  localparam int W  = Q + F;
  localparam int XW = W + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [W-1:0] K_INV   = 18'h09B75;
  localparam logic [W-1:0] HALF_PI = 18'h19220;

  // round(atan(2^-i) * 2^F), i = 0..F-1
  localparam logic [W-1:0] ATAN [F] = '{
    18'h0C910, 18'h076B2, 18'h03EB7, 18'h01FD6,
    18'h00FFB, 18'h007FF, 18'h00400, 18'h00200,
    18'h00100, 18'h00080, 18'h00040, 18'h00020,
    18'h00010, 18'h00008, 18'h00004, 18'h00002
  };

endpackage

// File: rtl/cordic_rotator_if.sv
// Request/result bundle between an angle source and the CORDIC rotator.
interface cordic_rotator_if #(
  parameter int W = cordic_pkg::W
);

  logic         start;
  logic [W-1:0] angle_in;
  logic         invalid_in;
  logic         busy;
  logic         done;
  logic [W-1:0] cos_out;
  logic [W-1:0] sin_out;
  logic         error;

  modport master (
    output start, angle_in, invalid_in,
    input  busy, done, cos_out, sin_out, error
  );

  modport slave (
    input  start, angle_in, invalid_in,
    output busy, done, cos_out, sin_out, error
  );

endinterface

// File: rtl/cordic_iter_step.sv
// One combinational CORDIC micro-rotation in rotation mode.
module cordic_iter_step
  import cordic_pkg::*;
#(
  parameter int XW = cordic_pkg::XW,
  parameter int IW = $clog2(cordic_pkg::F)
) (
  input  logic signed [XW-1:0] x_in,
  input  logic signed [XW-1:0] y_in,
  input  logic signed [XW-1:0] z_in,
  input  logic        [IW-1:0] i_in,
  output logic signed [XW-1:0] x_out,
  output logic signed [XW-1:0] y_out,
  output logic signed [XW-1:0] z_out
);

  logic signed [XW-1:0] x_sh;
  logic signed [XW-1:0] y_sh;
  logic signed [XW-1:0] atan_x;

  assign x_sh   = x_in >>> i_in;
  assign y_sh   = y_in >>> i_in;
  assign atan_x = $signed(XW'(ATAN[i_in]));

  // Negative residual angle rotates clockwise (d = -1), otherwise counter-clockwise.
  always_comb begin
    x_out = x_in - y_sh;
    y_out = y_in + x_sh;
    z_out = z_in - atan_x;
    if (z_in[XW-1]) begin
      x_out = x_in + y_sh;
      y_out = y_in - x_sh;
      z_out = z_in + atan_x;
    end
  end

endmodule

// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotator: one micro-rotation per clock, producing cos/sin of a Q.F angle.
//   state   | meaning
//   ST_IDLE | waiting for start; inputs sampled here only
//   ST_ITER | running micro-rotations, i counts 0..ITER-1
//   ST_DONE | results valid, done high for this single cycle
module cordic_rotator
  import cordic_pkg::*;
#(
  parameter int Q    = cordic_pkg::Q,
  parameter int F    = cordic_pkg::F,
  parameter int ITER = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  cordic_rotator_if.slave bus
);

  localparam int W  = Q + F;
  localparam int XW = W + 2;
  localparam int CW = $clog2(ITER + 1);
  localparam int IW = $clog2(F);

  localparam logic signed [XW-1:0] HALF_PI_X = $signed(XW'(HALF_PI));
  localparam logic signed [XW-1:0] K_INV_X   = $signed(XW'(K_INV));

  state_t               state;
  logic signed [XW-1:0] x_q, y_q, z_q;
  logic        [CW-1:0] i_q;
  logic signed [XW-1:0] x_n, y_n, z_n;
  logic        [IW-1:0] step_i;
  logic                 busy_q, done_q, err_q;
  logic        [W-1:0]  cos_q, sin_q;

  logic signed [XW-1:0] angle_x;
  logic signed [XW-1:0] angle_abs;
  logic                 reject;

  assign angle_x   = XW'($signed(bus.angle_in));
  assign angle_abs = angle_x[XW-1] ? -angle_x : angle_x;
  assign reject    = bus.invalid_in || (angle_abs > HALF_PI_X);
  assign step_i    = IW'(i_q);

  cordic_iter_step #(
    .XW (XW),
    .IW (IW)
  ) u_step (
    .x_in  (x_q),
    .y_in  (y_q),
    .z_in  (z_q),
    .i_in  (step_i),
    .x_out (x_n),
    .y_out (y_n),
    .z_out (z_n)
  );

  // Clamp the guard-bit datapath back to the W-bit output format.
  function automatic logic [W-1:0] sat(input logic signed [XW-1:0] v);
    if (&v[XW-1:W-1] || ~|v[XW-1:W-1]) begin
      sat = v[W-1:0];
    end else if (v[XW-1]) begin
      sat = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat = {1'b0, {(W-1){1'b1}}};
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      i_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cos_q  <= '0;
      sin_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            busy_q <= 1'b1;
            if (reject) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
              cos_q  <= '0;
              sin_q  <= '0;
            end else begin
              state <= ST_ITER;
              x_q   <= K_INV_X;
              y_q   <= '0;
              z_q   <= angle_x;
              i_q   <= '0;
            end
          end
        end
        ST_ITER: begin
          x_q <= x_n;
          y_q <= y_n;
          z_q <= z_n;
          i_q <= i_q + CW'(1);
          // Final rotation result is registered straight into the outputs.
          if (i_q == CW'(ITER - 1)) begin
            state  <= ST_DONE;
            done_q <= 1'b1;
            err_q  <= 1'b0;
            cos_q  <= sat(x_n);
            sin_q  <= sat(y_n);
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.error   = err_q;
  assign bus.cos_out = cos_q;
  assign bus.sin_out = sin_q;

endmodule

// File: tb/tb_cordic_rotator.sv
// Scoreboard bench for cordic_rotator: directed angles with hand-computed cos/sin.
module tb_cordic_rotator;

  localparam int W = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int exp_cos;
    int exp_sin;
    int exp_err;
    int tol;
    int lat;
    int start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  cordic_rotator_if #(.W(W)) bus ();

  cordic_rotator #(.Q(2), .F(16), .ITER(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act - exp > tol || exp - act > tol) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d tol=%0d t=%0t", name, act, exp, tol, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("cos", int'($signed(bus.cos_out)), mon_e.exp_cos, mon_e.tol);
        chk("sin", int'($signed(bus.sin_out)), mon_e.exp_sin, mon_e.tol);
        chk("error", int'(bus.error), mon_e.exp_err, 0);
        chk("latency", cyc - mon_e.start_cyc + 1, mon_e.lat, 0);
        chk("busy_in_done", int'(bus.busy), 1, 0);
      end
    end
  end

  // Called at a negedge; issues one request and waits for the block to go idle.
  task automatic run_op(input logic [W-1:0] ang, input logic inv,
                        input int ec, input int es, input int ee,
                        input int repulse_at, input logic [W-1:0] repulse_ang);
    exp_t e;
    bit   idle;
    bus.angle_in   = ang;
    bus.invalid_in = inv;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    e.exp_cos   = ec;
    e.exp_sin   = es;
    e.exp_err   = ee;
    e.tol       = ee ? 0 : 4;
    e.lat       = ee ? 1 : 17;
    e.start_cyc = cyc;
    sb.push_back(e);
    bus.start      = 1'b0;
    bus.invalid_in = 1'b0;
    idle = 1'b0;
    for (int k = 1; k <= 40 && !idle; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == repulse_at) begin
        bus.angle_in = repulse_ang;
        bus.start    = 1'b1;
      end
      if (!bus.busy && k > 1) idle = 1'b1;
    end
    bus.start = 1'b0;
    if (!idle) chk("op_timeout", 1, 0, 0);
    repeat (3) @(negedge clk);
    chk("hold_busy", int'(bus.busy), 0, 0);
    chk("hold_error", int'(bus.error), ee, 0);
    chk("hold_cos", int'($signed(bus.cos_out)), ec, e.tol);
    chk("hold_sin", int'($signed(bus.sin_out)), es, e.tol);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.angle_in   = '0;
    bus.invalid_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(bus.busy), 0, 0);
    chk("rst_done", int'(bus.done), 0, 0);
    chk("rst_error", int'(bus.error), 0, 0);
    chk("rst_cos", int'(bus.cos_out), 0, 0);
    chk("rst_sin", int'(bus.sin_out), 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_op(18'h00000, 1'b0, 65536, 0, 0, 0, '0);
    run_op(18'h0860B, 1'b0, 56756, 32768, 0, 0, '0);
    run_op(18'h336F0, 1'b0, 46341, -46341, 0, 0, '0);
    run_op(18'h10C15, 1'b0, 32768, 56756, 0, 0, '0);
    run_op(18'h19220, 1'b0, 0, 65536, 0, 0, '0);
    run_op(18'h26DE0, 1'b0, 0, -65536, 0, 0, '0);
    run_op(18'h00000, 1'b1, 0, 0, 1, 0, '0);
    run_op(18'h1A000, 1'b0, 0, 0, 1, 0, '0);
    run_op(18'h19221, 1'b0, 0, 0, 1, 0, '0);
    run_op(18'h26DDF, 1'b0, 0, 0, 1, 0, '0);
    run_op(18'h0860B, 1'b0, 56756, 32768, 0, 5, 18'h1A000);

    // Abort an operation with reset; no done may follow it.
    bus.angle_in = 18'h336F0;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("abort_busy_before", int'(bus.busy), 1, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0, 0);
    chk("abort_done", int'(bus.done), 0, 0);
    chk("abort_cos", int'(bus.cos_out), 0, 0);
    chk("abort_sin", int'(bus.sin_out), 0, 0);
    chk("abort_error", int'(bus.error), 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_op(18'h336F0, 1'b0, 46341, -46341, 0, 0, '0);

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    chk("pending_results", sb.size(), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
